rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
Owns the single write port of the general-purpose register file and shares it between two writeback sources: ALU (source 0) and LSU (source 1), each on a valid/ready handshake.
Holds a per-register pending-write scoreboard. Decode uses it to detect RAW/WAW hazards on rs1/rs2/rd and stall.
Sits between the execute/memory stages and reg_file. Drives reg_file write_data_i/write_addr_i/write_en_i from a registered output stage.

Parameters:
DATA_WIDTH, `RISCV_WORD_WIDTH (32), width of writeback data
REG_COUNT, `GP_REG_COUNT (32), number of architectural registers
ADDR_WIDTH, $clog2(REG_COUNT), register index width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
alu_valid_i  in  1  ALU writeback request
alu_addr_i  in  ADDR_WIDTH  ALU destination register
alu_data_i  in  DATA_WIDTH  ALU result
alu_ready_o  out  1  ALU request accepted this cycle
lsu_valid_i  in  1  LSU writeback request
lsu_addr_i  in  ADDR_WIDTH  LSU destination register
lsu_data_i  in  DATA_WIDTH  load data
lsu_ready_o  out  1  LSU request accepted this cycle
issue_en_i  in  1  decode issues an instruction that writes rd
issue_addr_i  in  ADDR_WIDTH  rd of issued instruction
flush_i  in  1  clear all pending bits
rs1_addr_i  in  ADDR_WIDTH  decode rs1 query
rs2_addr_i  in  ADDR_WIDTH  decode rs2 query
rd_addr_i  in  ADDR_WIDTH  decode rd query
rs1_busy_o  out  1  rs1 has pending write
rs2_busy_o  out  1  rs2 has pending write
rd_busy_o  out  1  rd has pending write
rf_write_data_o  out  DATA_WIDTH  to reg_file write_data_i
rf_write_addr_o  out  ADDR_WIDTH  to reg_file write_addr_i
rf_write_en_o  out  1  to reg_file write_en_i

Behaviour:
- Reset (rst=1 at edge):
  - rf_write_en_o/addr/data = 0.
  - All pending bits = 0.
  - last_grant = LSU, so ALU wins the first conflict.
- Handshake:
  - Transfer occurs when valid_i && ready_o in the same cycle.
  - Source holds valid/addr/data stable until accepted.
  - ready_o is combinational from both valids and last_grant; it is 0 when the source's own valid is 0.
- Arbitration: round-robin, at most one grant per cycle.
  - One valid requester: it is granted.
  - Both valid: the source not in last_grant is granted.
  - last_grant updates only on a grant.
  - The output stage never stalls.
- Output latency: 1 cycle.
  - Request accepted at edge N: rf_write_*_o are valid during cycle N+1, and reg_file captures at edge N+1.
  - rf_write_en_o is 0 in any cycle following a cycle with no grant.
  - A granted write to x0 is accepted (ready=1) but produces rf_write_en_o=0.
- Scoreboard: REG_COUNT pending bits; bit 0 is hard-wired 0.
  - Set: issue_en_i at edge, with issue_addr_i != 0.
  - Clear: at the edge where rf_write_en_o=1 for rf_write_addr_o, i.e. the same edge reg_file is written.
  - Same-edge set and clear on the same register: set wins (new producer).
  - flush_i clears all bits at the edge. Set and clear in that same cycle are ignored.
  - In-flight accepted writes still commit after a flush.
- busy outputs:
  - Combinational from the pending bits; no bypass of same-cycle set/clear.
  - Address 0 always reports not busy.
- Decode must stall on rd_busy_o before issuing. WAW tracking is single-bit and relies on this rule.
- rst asserted mid-transfer drops the registered write (rf_write_en_o=0 next cycle) and clears the scoreboard.

Decomposition:
- Shared package rf_pkg: DATA_WIDTH/REG_COUNT/ADDR_WIDTH constants, wb_src_e enum {WB_SRC_ALU, WB_SRC_LSU}, and wb_req_t struct {valid, addr, data}.
- One natural sub-module: rf_scoreboard, holding the pending bit vector, set/clear/flush logic and the three busy lookups.
- Arbiter and output register stay in the top.

Test Plan:
- Reset, then ALU valid addr=5 data=0xDEADBEEF alone -> alu_ready_o=1 same cycle; next cycle rf_write_en_o=1, addr=5, data=0xDEADBEEF; following cycle en=0.
- ALU and LSU valid together for 4 cycles (addrs 1..4) -> grants ALU, LSU, ALU, LSU; each source holds until its ready; outputs follow 1 cycle later in that order.
- issue rd=7, then rs1_addr=7 -> rs1_busy_o=1 next cycle; LSU writes 7 -> busy stays 1 during the output cycle and is 0 the cycle after.
- Same edge: rf_write_en_o for x9 and issue_en_i with addr 9 -> pending[9]=1 afterward.
- LSU write to x0 data=0x1 -> lsu_ready_o=1; rf_write_en_o stays 0; issue rd=0 -> rd_busy_o for addr 0 stays 0.
- Set pending on x3 and x4, accept ALU write x3, assert flush_i -> all busy 0; rf_write_en_o=1 for x3 still appears next cycle. Then assert rst -> all outputs 0, and the next ALU/LSU conflict grants ALU.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, writeback source enum and request struct
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bits with busy lookups
module rf_scoreboard #(
    parameter  int REG_COUNT  = rf_pkg::REG_COUNT,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rd_busy_o
);

    logic [REG_COUNT-1:0] pending_q;
    logic [REG_COUNT-1:0] pending_d;

    // Clear before set so a new producer issued on the commit edge stays pending.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if (clr_en_i) begin
                pending_d[clr_addr_i] = 1'b0;
            end
            if (set_en_i) begin
                pending_d[set_addr_i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_busy_o = pending_q[rs1_addr_i];
    assign rs2_busy_o = pending_q[rs2_addr_i];
    assign rd_busy_o  = pending_q[rd_addr_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin ALU/LSU writeback arbiter driving the register file write port
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter  int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter  int REG_COUNT  = rf_pkg::REG_COUNT,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    output logic                  alu_ready_o,
    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    output logic                  lsu_ready_o,
    input  logic                  issue_en_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rd_busy_o,
    output logic [DATA_WIDTH-1:0] rf_write_data_o,
    output logic [ADDR_WIDTH-1:0] rf_write_addr_o,
    output logic                  rf_write_en_o
);

    wb_src_e               last_grant_q, last_grant_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  alu_grant, lsu_grant;

    // On conflict the source that did not win last time is favoured.
    always_comb begin
        alu_grant    = alu_valid_i && (!lsu_valid_i || (last_grant_q == WB_SRC_LSU));
        lsu_grant    = lsu_valid_i && (!alu_valid_i || (last_grant_q == WB_SRC_ALU));
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        if (alu_grant) begin
            last_grant_d = WB_SRC_ALU;
            wr_en_d      = (alu_addr_i != '0);
            wr_addr_d    = alu_addr_i;
            wr_data_d    = alu_data_i;
        end else if (lsu_grant) begin
            last_grant_d = WB_SRC_LSU;
            wr_en_d      = (lsu_addr_i != '0);
            wr_addr_d    = lsu_addr_i;
            wr_data_d    = lsu_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= WB_SRC_LSU;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign alu_ready_o     = alu_grant;
    assign lsu_ready_o     = lsu_grant;
    assign rf_write_en_o   = wr_en_q;
    assign rf_write_addr_o = wr_addr_q;
    assign rf_write_data_o = wr_data_q;

    // Pending bits clear on the same edge the register file captures the write.
    rf_scoreboard #(
        .REG_COUNT (REG_COUNT)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (issue_en_i && (issue_addr_i != '0)),
        .set_addr_i (issue_addr_i),
        .clr_en_i   (wr_en_q),
        .clr_addr_i (wr_addr_q),
        .flush_i    (flush_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rs1_busy_o (rs1_busy_o),
        .rs2_busy_o (rs2_busy_o),
        .rd_busy_o  (rd_busy_o)
    );

endmodule
